// File: rtl/cnu6_ib_ram_loader_pkg.sv
// Shared sizing and FSM encoding for the CNU6 IB-LUT mapper and the IB RAM loader.
// The mapper, the loader and the RAM all import these values.
package cnu6_ib_ram_loader_pkg;

    localparam int QUAN_SIZE = 4;
    localparam int BANK_NUM  = 8;
    localparam int PORT_NUM  = 4;
    localparam int BW        = QUAN_SIZE * PORT_NUM;
    localparam int DEPTH     = 32;
    localparam int ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/cnu6_ib_ram_loader_bank_wr_chan.sv
// One bank's write channel: saturating address counter, full flag, overflow detect
// and the registered we/waddr/wdata driving a single cnu_ib_ram bank.
module cnu_ib_bank_wr_chan
    import cnu6_ib_ram_loader_pkg::*;
(
    input  logic              sys_clk,
    input  logic              rstn,
    input  logic              clear,
    input  logic              accept_en,
    input  logic              valid,
    input  logic [BW-1:0]     data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [BW-1:0]     wdata,
    output logic              full,
    output logic              ovf_det
);

    logic [ADDR_W-1:0] cnt;
    logic              wr_ok;

    assign wr_ok   = accept_en & valid & ~full;
    assign ovf_det = accept_en & valid & full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            cnt   <= '0;
            full  <= 1'b0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (clear) begin
            cnt  <= '0;
            full <= 1'b0;
            we   <= 1'b0;
        end else begin
            we <= wr_ok;
            if (wr_ok) begin
                waddr <= cnt;
                wdata <= data;
                // Counter saturates on the last address; full marks the bank complete.
                if (cnt == ADDR_W'(DEPTH - 1))
                    full <= 1'b1;
                else
                    cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnu6_ib_ram_loader.sv
// Loads BANK_NUM IB RAM banks from the CNU6 IB-LUT mapper, one word per valid
// strobe per bank, and reports a single load_done once every bank is full.
module cnu6_ib_ram_loader
    import cnu6_ib_ram_loader_pkg::*;
(
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic                       load_start,
    input  logic                       load_abort,
    input  logic [BANK_NUM*BW-1:0]     bank_data,
    input  logic [BANK_NUM-1:0]        bank_valid,
    output logic [BANK_NUM-1:0]        ram_we,
    output logic [BANK_NUM*ADDR_W-1:0] ram_waddr,
    output logic [BANK_NUM*BW-1:0]     ram_wdata,
    output logic                       busy,
    output logic                       load_done,
    output logic                       overflow
);

    load_state_t         state_q, state_d;
    logic [BANK_NUM-1:0] full;
    logic [BANK_NUM-1:0] ovf_det;
    logic                all_full;
    logic                chan_clear;
    logic                accept_en;

    assign all_full   = &full;
    assign chan_clear = load_start | load_abort;
    // Start/abort cycles are control-only: that cycle's bank_valid is never written.
    assign accept_en  = (state_q == LD_LOAD) & ~load_start & ~load_abort;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) state_q <= LD_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (load_abort)
            state_d = LD_IDLE;
        else if (load_start)
            state_d = LD_LOAD;
        else if (state_q == LD_LOAD && all_full)
            state_d = LD_DONE;
    end

    always_comb begin
        busy      = (state_q == LD_LOAD);
        load_done = (state_q == LD_DONE);
    end

    // Sticky until a load actually (re)starts; an abort keeps it for inspection.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn)
            overflow <= 1'b0;
        else if (load_start && !load_abort)
            overflow <= 1'b0;
        else if (|ovf_det)
            overflow <= 1'b1;
    end

    for (genvar i = 0; i < BANK_NUM; i++) begin : g_chan
        cnu_ib_bank_wr_chan u_chan (
            .sys_clk   (sys_clk),
            .rstn      (rstn),
            .clear     (chan_clear),
            .accept_en (accept_en),
            .valid     (bank_valid[i]),
            .data      (bank_data[i*BW +: BW]),
            .we        (ram_we[i]),
            .waddr     (ram_waddr[i*ADDR_W +: ADDR_W]),
            .wdata     (ram_wdata[i*BW +: BW]),
            .full      (full[i]),
            .ovf_det   (ovf_det[i])
        );
    end

endmodule

// File: doc/cnu6_ib_ram_loader.md
Name: cnu6_ib_ram_loader

Overview:
- Downstream consumer of the CNU6 IB-LUT bank mapper.
- Takes 8 banks x 4 ports of QUAN_SIZE-bit LUT entries plus a per-bank valid strobe.
- Writes each bank's 16-bit word into its own cnu_ib_ram bank through a registered write port, with a per-bank address counter.
- A start/abort/done FSM gives the decoder a single load_done indication once every bank is fully populated.

Parameters:
- QUAN_SIZE, 4, bits per LUT entry.
- BANK_NUM, 8, number of cnu_ib_ram banks.
- PORT_NUM, 4, entries per bank word; bank word width BW = QUAN_SIZE*PORT_NUM = 16.
- DEPTH, 32, words written per bank per load.
- ADDR_W, 5, RAM address width; ceil(log2(DEPTH)).

Ports:
- sys_clk, input, 1, clock; all state updates on rising edge (mapper output changes on falling edge, giving a half-cycle setup).
- rstn, input, 1, reset: asynchronous, active-low.
- load_start, input, 1, one-cycle pulse; begins or restarts a load.
- load_abort, input, 1, one-cycle pulse; cancels a load.
- bank_data, input, BANK_NUM*BW, packed words; bank i occupies [i*BW +: BW], portA in the MSBs.
- bank_valid, input, BANK_NUM, bit i qualifies bank i's word for this cycle.
- ram_we, output, BANK_NUM, registered write enables.
- ram_waddr, output, BANK_NUM*ADDR_W, registered per-bank write address.
- ram_wdata, output, BANK_NUM*BW, registered per-bank write data.
- busy, output, 1, high in LOAD.
- load_done, output, 1, level; high in DONE.
- overflow, output, 1, sticky error flag.

Behaviour:
- Reset values: ram_we=0, ram_waddr=0, ram_wdata=0, busy=0, load_done=0, overflow=0, FSM=IDLE, all counters=0, all full flags=0.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_start -> LOAD.
  - On entry to LOAD, counters, full flags and overflow are cleared.
  - bank_valid is ignored in IDLE, including the cycle in which load_start is sampled.
- LOAD, bank i with bank_valid[i]=1 and not full:
  - Next cycle: ram_we[i]=1, ram_waddr[i]=cnt[i], ram_wdata[i]=bank_data[i].
  - cnt[i] increments; full[i] sets when cnt[i] reaches DEPTH-1 at write time.
  - Latency is 1 cycle, valid to we.
  - Banks are independent; any subset can write in the same cycle.
- LOAD, bank_valid[i]=1 while full[i]=1: no write; overflow sets and stays set until the next load_start.
- ram_we[i] is low in any cycle without an accepted write; waddr/wdata hold their last values.
- LOAD -> DONE in the cycle after the last bank's final write is registered, i.e. when all full flags are set. load_done rises the same cycle as the FSM enters DONE, one cycle after the last ram_we pulse.
- DONE:
  - Holds load_done=1. bank_valid is ignored, with no overflow set.
  - load_start -> LOAD (new load, counters cleared).
- load_abort in LOAD or DONE -> IDLE next cycle:
  - Counters and full flags cleared; in-flight write enables are suppressed in that cycle.
  - overflow is retained for inspection.
- Simultaneous events:
  - load_abort has priority over load_start.
  - load_start in LOAD restarts: counters cleared and that cycle's bank_valid is ignored.
  - bank_valid[i] arriving in the same cycle that the last bank becomes full is still written if bank i is not full.
- Counter wrap: cnt never wraps; it saturates at DEPTH-1 with full set. DEPTH that is not a power of two is legal.
- Async reset mid-load: all outputs go to reset values immediately and the load is lost; a new load_start is required.
- busy = (FSM==LOAD); busy and load_done are never high together.

Decomposition:
- Shared define header holds QUAN_SIZE, bank count, port count, IB RAM depth and address width, and the FSM state encodings, so the mapper and RAM use identical values.
- One natural sub-module, cnu_ib_bank_wr_chan, instantiated BANK_NUM times. It contains:
  - the address counter and full flag;
  - the overflow detect;
  - the registered we/waddr/wdata.
- The top level contains the FSM, the all-full AND-reduction and the sticky overflow OR.

Test Plan:
- Reset mid-load: assert rstn=0 after 10 writes to bank 0 -> all outputs 0, state IDLE; a later bank_valid without load_start produces no ram_we.
- Nominal load: load_start, then bank_valid=8'hFF for 32 cycles with bank i data = {i,cycle}:
  - each ram_we[i] pulses 32 times at addresses 0..31 with matching data, 1-cycle latency;
  - load_done rises one cycle after the 32nd write; busy falls the same cycle.
- Skewed banks: bank_valid rotating one-hot (8'h01, 8'h02, ...) for 256 cycles -> each bank gets 32 sequential writes; load_done only after bank 7's 32nd write.
- Overflow: bank 3 fully written (32 valids) and all other banks left short, then one more bank_valid[3] -> no ram_we[3], overflow=1, state stays LOAD; overflow clears on the next load_start.
- Abort/restart:
  - load_abort after 5 writes -> IDLE; load_start then begins at ram_waddr 0.
  - load_start and load_abort in the same cycle -> IDLE.
- Start-cycle masking: load_start with bank_valid=8'hFF in the same cycle -> no write that cycle; the first ram_we (addr 0) follows the next valid.
